lsu: RTL

Load/store unit sitting directly downstream of the ALU in the RV32I datapath. It takes the ALU result as the effective address and drives a word-wide data-memory bus with a req/ack handshake. It also generates byte masks, replicates store data, and extracts and sign- or zero-extends load data for writeback. While an access is in flight, it stalls the single-cycle core. A watchdog aborts requests that are never acknowledged.

---
 rtl/lsu.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// RV32I load/store unit: word bus with req/ack, byte masks, store replication, load extension, watchdog.
// Optional feature macro LSU_MISALIGN_TRAP_EN: reject misaligned accesses instead of forcing alignment.
module lsu #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lsu_valid,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic        o_stall,
    output logic [31:0] o_ld_data,
    output logic        o_ld_valid,
    output logic        o_bus_err,
    output logic        o_misaligned,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    localparam bit          LP_WD_EN = (TIMEOUT_CYC != 0);
    localparam logic [31:0] LP_LAST  = 32'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_next;

    logic [29:0] r_waddr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [3:0]  r_bmask;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_off;
    logic        r_err;
    logic [31:0] r_ld_data;
    logic [31:0] r_cnt;

    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic        w_mis;
    logic [3:0]  w_bmask;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_ext;
    logic        w_wd_exp;
    logic        w_accept;

    // Size encoding: 0 = byte, 1 = half, 2 = word (funct3 size 11 folds into word).
    always_comb begin
        case (i_funct3[1:0])
            2'b00:   w_size = 2'd0;
            2'b01:   w_size = 2'd1;
            default: w_size = 2'd2;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_mis;
    assign w_off = i_addr[1:0];
    assign w_mis = ((w_size == 2'd1) && i_addr[0]) ||
                   ((w_size == 2'd2) && (i_addr[1:0] != 2'b00));
    assign o_misaligned = (r_state == S_RESP) && r_mis;
`else
    assign w_off = (w_size == 2'd0) ? i_addr[1:0] :
                   (w_size == 2'd1) ? {i_addr[1], 1'b0} : 2'b00;
    assign w_mis = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    always_comb begin
        case (w_size)
            2'd0:    begin w_bmask = 4'b0001 << w_off;              w_wdata = {4{i_st_data[7:0]}};  end
            2'd1:    begin w_bmask = 4'b0011 << {w_off[1], 1'b0};   w_wdata = {2{i_st_data[15:0]}}; end
            default: begin w_bmask = 4'b1111;                        w_wdata = i_st_data;            end
        endcase
    end

    // Halfword offsets are always even here, so a byte-granular shift serves both sizes.
    assign w_shift = i_mem_rdata >> {r_off, 3'b000};

    always_comb begin
        case (r_size)
            2'd0:    w_ext = r_uns ? {24'd0, w_shift[7:0]}  : {{24{w_shift[7]}}, w_shift[7:0]};
            2'd1:    w_ext = r_uns ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_ext = i_mem_rdata;
        endcase
    end

    assign w_wd_exp = LP_WD_EN && (r_cnt == LP_LAST) && !i_mem_ack;
    assign w_accept = (r_state == S_IDLE) && i_lsu_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_lsu_valid) w_next = w_mis ? S_RESP : S_BUS;
            S_BUS:  if (i_mem_ack || w_wd_exp) w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_waddr   <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_bmask   <= '0;
            r_size    <= '0;
            r_uns     <= 1'b0;
            r_off     <= '0;
            r_err     <= 1'b0;
            r_ld_data <= '0;
            r_cnt     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_mis     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_waddr <= i_addr[31:2];
            r_we    <= i_lsu_wren;
            r_wdata <= w_wdata;
            r_bmask <= w_bmask;
            r_size  <= w_size;
            r_uns   <= i_funct3[2];
            r_off   <= w_off;
            r_err   <= 1'b0;
            r_cnt   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_mis   <= w_mis;
            if (w_mis) r_ld_data <= '0;
`endif
        end else if (r_state == S_BUS) begin
            if (i_mem_ack) begin
                r_ld_data <= r_we ? 32'd0 : w_ext;
            end else if (w_wd_exp) begin
                r_err     <= 1'b1;
                r_ld_data <= '0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    // Bus fields are only presented while the request is outstanding.
    assign o_mem_req   = (r_state == S_BUS);
    assign o_mem_we    = o_mem_req & r_we;
    assign o_mem_addr  = o_mem_req ? {r_waddr, 2'b00} : 32'd0;
    assign o_mem_wdata = o_mem_req ? r_wdata : 32'd0;
    assign o_mem_bmask = o_mem_req ? r_bmask : 4'd0;

    assign o_stall    = i_rst_n & (w_accept | (r_state == S_BUS));
    assign o_ld_data  = r_ld_data;
    assign o_bus_err  = (r_state == S_RESP) && r_err;
`ifdef LSU_MISALIGN_TRAP_EN
    assign o_ld_valid = (r_state == S_RESP) && !r_we && !r_err && !r_mis;
`else
    assign o_ld_valid = (r_state == S_RESP) && !r_we && !r_err;
`endif

endmodule
